// File: rtl/energy_cal_quad_eval.sv
// Per-channel quadratic energy calibration: e = ((c2*p >>> 15) + c1)*p >>> 15 + c0, clamped to [0, 2^EW-1].
// Optional saturation counter port sat_count is built when ENERGY_CAL_SAT_CNT_EN is defined.
module energy_cal_quad_eval #(
  parameter int CHAN_W      = 10,
  parameter int PH_W        = 16,
  parameter int TS_W        = 32,
  parameter int EW          = 16,
  parameter int LUT_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              photon_valid,
  input  logic [CHAN_W-1:0] photon_chan,
  input  logic [PH_W-1:0]   photon_phase,
  input  logic [TS_W-1:0]   photon_ts,
  output logic [CHAN_W-1:0] bram_addr,
  output logic              bram_en_a,
  output logic              bram_we,
  output logic [63:0]       bram_wr_data,
  input  logic [63:0]       bram_rd_data,
  output logic              energy_valid,
  output logic [EW-1:0]     energy,
  output logic [CHAN_W-1:0] energy_chan,
  output logic [TS_W-1:0]   energy_ts
`ifdef ENERGY_CAL_SAT_CNT_EN
  ,
  output logic [31:0]       sat_count
`endif
);

  // The LUT samples the address on the same edge that accepts the photon.
  assign bram_addr    = photon_chan;
  assign bram_en_a    = !rst;
  assign bram_we      = 1'b0;
  assign bram_wr_data = '0;

  logic              sb_valid_q [LUT_LATENCY];
  logic [PH_W-1:0]   sb_phase_q [LUT_LATENCY];
  logic [CHAN_W-1:0] sb_chan_q  [LUT_LATENCY];
  logic [TS_W-1:0]   sb_ts_q    [LUT_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LUT_LATENCY; i++) sb_valid_q[i] <= 1'b0;
    end else begin
      sb_valid_q[0] <= photon_valid;
      for (int i = 1; i < LUT_LATENCY; i++) sb_valid_q[i] <= sb_valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    sb_phase_q[0] <= photon_phase;
    sb_chan_q[0]  <= photon_chan;
    sb_ts_q[0]    <= photon_ts;
    for (int i = 1; i < LUT_LATENCY; i++) begin
      sb_phase_q[i] <= sb_phase_q[i-1];
      sb_chan_q[i]  <= sb_chan_q[i-1];
      sb_ts_q[i]    <= sb_ts_q[i-1];
    end
  end

  logic signed [15:0] c2_w, c1_w;
  logic signed [31:0] c0_w;
  logic signed [15:0] p_w;
  assign c2_w = signed'(bram_rd_data[63:48]);
  assign c1_w = signed'(bram_rd_data[47:32]);
  assign c0_w = signed'(bram_rd_data[31:0]);
  assign p_w  = signed'(sb_phase_q[LUT_LATENCY-1]);

  // Stage registers; data paths are unreset, only the valid chain is.
  logic                     s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [31:0]       s1_m1_q;
  logic signed [15:0]       s1_c1_q, s1_p_q, s2_p_q;
  logic signed [31:0]       s1_c0_q, s2_c0_q, s3_c0_q;
  logic signed [17:0]       s2_t1_q;
  logic signed [33:0]       s3_m2_q;
  logic [CHAN_W-1:0]        s1_chan_q, s2_chan_q, s3_chan_q;
  logic [TS_W-1:0]          s1_ts_q, s2_ts_q, s3_ts_q;

  logic signed [31:0] m1_d;
  logic signed [16:0] m1_sh;
  logic signed [17:0] t1_d;
  logic signed [33:0] m2_d;
  logic signed [18:0] m2_sh;
  logic signed [32:0] e_d;
  logic [EW-1:0]      clamp_d;
  logic               sat_d;

  assign m1_d  = 32'(c2_w) * 32'(p_w);
  assign m1_sh = s1_m1_q[31:15];
  assign t1_d  = {m1_sh[16], m1_sh} + {{2{s1_c1_q[15]}}, s1_c1_q};
  assign m2_d  = 34'(s2_t1_q) * 34'(s2_p_q);
  assign m2_sh = s3_m2_q[33:15];
  assign e_d   = {{14{m2_sh[18]}}, m2_sh} + {s3_c0_q[31], s3_c0_q};

  always_comb begin
    clamp_d = e_d[EW-1:0];
    sat_d   = 1'b0;
    if (e_d[32]) begin
      clamp_d = '0;
      sat_d   = 1'b1;
    end else if (|e_d[31:EW]) begin
      clamp_d = '1;
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= sb_valid_q[LUT_LATENCY-1];
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    s1_m1_q   <= m1_d;
    s1_c1_q   <= c1_w;
    s1_c0_q   <= c0_w;
    s1_p_q    <= p_w;
    s1_chan_q <= sb_chan_q[LUT_LATENCY-1];
    s1_ts_q   <= sb_ts_q[LUT_LATENCY-1];
    s2_t1_q   <= t1_d;
    s2_p_q    <= s1_p_q;
    s2_c0_q   <= s1_c0_q;
    s2_chan_q <= s1_chan_q;
    s2_ts_q   <= s1_ts_q;
    s3_m2_q   <= m2_d;
    s3_c0_q   <= s2_c0_q;
    s3_chan_q <= s2_chan_q;
    s3_ts_q   <= s2_ts_q;
  end

  // Output registers hold their last value between events.
  always_ff @(posedge clk) begin
    if (rst) begin
      energy_valid <= 1'b0;
      energy       <= '0;
      energy_chan  <= '0;
      energy_ts    <= '0;
    end else begin
      energy_valid <= s3_valid_q;
      if (s3_valid_q) begin
        energy      <= clamp_d;
        energy_chan <= s3_chan_q;
        energy_ts   <= s3_ts_q;
      end
    end
  end

`ifdef ENERGY_CAL_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (s3_valid_q && sat_d && (sat_count != '1)) begin
      sat_count <= sat_count + 32'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_d;
`endif

endmodule

// File: tb/tb_energy_cal_quad_eval.sv
// Bench for energy_cal_quad_eval: behavioural 3-cycle LUT on port A, directed photons, queued expectations.
// Build with ENERGY_CAL_SAT_CNT_EN defined to also check sat_count.
module tb_energy_cal_quad_eval;
  localparam int CHAN_W = 10;
  localparam int PH_W   = 16;
  localparam int TS_W   = 32;
  localparam int EW     = 16;
  localparam int LAT    = 7;
  // item: {exp_cyc[31:0], sat, energy[15:0], chan[9:0], ts[31:0]}
  localparam int SB_W   = 32 + 1 + EW + CHAN_W + TS_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              photon_valid;
  logic [CHAN_W-1:0] photon_chan;
  logic [PH_W-1:0]   photon_phase;
  logic [TS_W-1:0]   photon_ts;
  logic [CHAN_W-1:0] bram_addr;
  logic              bram_en_a;
  logic              bram_we;
  logic [63:0]       bram_wr_data;
  logic [63:0]       bram_rd_data;
  logic              energy_valid;
  logic [EW-1:0]     energy;
  logic [CHAN_W-1:0] energy_chan;
  logic [TS_W-1:0]   energy_ts;
`ifdef ENERGY_CAL_SAT_CNT_EN
  logic [31:0]       sat_count;
`endif

  energy_cal_quad_eval dut (
    .clk          (clk),
    .rst          (rst),
    .photon_valid (photon_valid),
    .photon_chan  (photon_chan),
    .photon_phase (photon_phase),
    .photon_ts    (photon_ts),
    .bram_addr    (bram_addr),
    .bram_en_a    (bram_en_a),
    .bram_we      (bram_we),
    .bram_wr_data (bram_wr_data),
    .bram_rd_data (bram_rd_data),
    .energy_valid (energy_valid),
    .energy       (energy),
    .energy_chan  (energy_chan),
    .energy_ts    (energy_ts)
`ifdef ENERGY_CAL_SAT_CNT_EN
    ,
    .sat_count    (sat_count)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: address registered, then two output register stages.
  logic [63:0]       lut [0:1023];
  logic [CHAN_W-1:0] ra_q = '0;
  logic [63:0]       rd1_q = '0, rd2_q = '0;
  always @(posedge clk) begin
    if (bram_en_a) ra_q <= bram_addr;
    rd1_q <= lut[ra_q];
    rd2_q <= rd1_q;
  end
  assign bram_rd_data = rd2_q;

  logic [SB_W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int unsigned exp_sat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [63:0] coef(input logic [15:0] c2, input logic [15:0] c1, input logic [31:0] c0);
    return {c2, c1, c0};
  endfunction

  // driver tasks
  task automatic drive_photon(input logic [CHAN_W-1:0] ch, input logic [PH_W-1:0] ph,
                              input logic [TS_W-1:0] ts, input logic [EW-1:0] exp_e,
                              input logic exp_s, input logic push);
    photon_valid = 1'b1;
    photon_chan  = ch;
    photon_phase = ph;
    photon_ts    = ts;
    if (push) exp_q.push_back({32'(cyc + LAT), exp_s, exp_e, ch, ts});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    photon_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    photon_valid = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, 64'(energy_valid), 64'd0);
    check({name, "_energy"}, 64'(energy), 64'd0);
    check({name, "_chan"}, 64'(energy_chan), 64'd0);
    check({name, "_ts"}, 64'(energy_ts), 64'd0);
`ifdef ENERGY_CAL_SAT_CNT_EN
    check({name, "_sat_count"}, 64'(sat_count), 64'd0);
`endif
    check({name, "_we"}, {63'd0, bram_we}, 64'd0);
    check({name, "_wr_data"}, bram_wr_data, 64'd0);
  endtask

  // scoreboard monitor
  initial begin
    logic [SB_W-1:0] it;
    forever begin
      @(negedge clk);
      if (energy_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(energy_chan), 64'hFFFF_FFFF);
        end else begin
          it = exp_q.pop_front();
          check("out_cycle", 64'(cyc), 64'(it[SB_W-1 -: 32]));
          check("out_energy", 64'(energy), 64'(it[CHAN_W+TS_W +: EW]));
          check("out_chan", 64'(energy_chan), 64'(it[TS_W +: CHAN_W]));
          check("out_ts", 64'(energy_ts), 64'(it[TS_W-1:0]));
`ifdef ENERGY_CAL_SAT_CNT_EN
          if (it[CHAN_W+TS_W+EW]) exp_sat++;
          check("sat_count", 64'(sat_count), 64'(exp_sat));
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    photon_valid = 1'b0;
    photon_chan  = '0;
    photon_phase = '0;
    photon_ts    = '0;
    for (int i = 0; i < 1024; i++) lut[i] = '0;
    lut[3]  = coef(16'd0, 16'd0, 32'd70000);
    lut[4]  = coef(16'd0, 16'd0, 32'd65535);
    lut[5]  = coef(16'd0, 16'd0, 32'd1000);
    lut[7]  = coef(16'd0, 16'd16384, 32'd0);
    lut[9]  = coef(16'd16384, 16'd0, 32'd100);
    lut[11] = coef(16'd0, 16'd1, 32'd5);
    lut[12] = coef(16'h8000, 16'h7FFF, 32'd100000);
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check("bram_en_in_reset", {63'd0, bram_en_a}, 64'd0);
    rst = 1'b0;
    idle(2);
    check("bram_en_run", {63'd0, bram_en_a}, 64'd1);

    // directed vectors, back-to-back
    drive_photon(10'd5,  16'd12345,  32'h1234_5678, 16'd1000,  1'b0, 1'b1);
    drive_photon(10'd7,  16'd8192,   32'd101,       16'd4096,  1'b0, 1'b1);
    drive_photon(10'd7,  16'hE000,   32'd102,       16'd0,     1'b1, 1'b1);
    drive_photon(10'd9,  16'd16384,  32'd103,       16'd4196,  1'b0, 1'b1);
    drive_photon(10'd3,  16'd500,    32'd104,       16'd65535, 1'b1, 1'b1);
    drive_photon(10'd4,  16'd500,    32'd105,       16'd65535, 1'b0, 1'b1);
    drive_photon(10'd11, 16'hFFFF,   32'd106,       16'd4,     1'b0, 1'b1);
    drive_photon(10'd12, 16'h8000,   32'd107,       16'd34465, 1'b0, 1'b1);
    idle(3);
    // isolated photon after a gap
    drive_photon(10'd5,  16'h8000,   32'hFFFF_FFFF, 16'd1000,  1'b0, 1'b1);
    drain("directed");
    idle(2);
    check("hold_energy", 64'(energy), 64'd1000);
    check("hold_valid", 64'(energy_valid), 64'd0);

    // stream: c0 = chan on every channel
    for (int i = 0; i < 1024; i++) lut[i] = coef(16'd0, 16'd0, 32'(i));
    for (int i = 0; i < 1024; i++)
      drive_photon(CHAN_W'(i), PH_W'(i * 37), 32'(i * 3 + 1), EW'(i), 1'b0, 1'b1);
    drain("stream");

    // reset mid-stream: rst high during the fifth photon
    for (int i = 0; i < 10; i++) begin
      rst = (i == 4);
      drive_photon(CHAN_W'(100 + i), 16'd7, 32'(5000 + i), EW'(100 + i), 1'b0, (i >= 5));
      if (i == 4) begin
        exp_sat = 0;
        check_zero_outputs("mid_reset");
      end
    end
    rst = 1'b0;
    drain("reset_stream");
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/energy_cal_quad_eval.md
# energy_cal_quad_eval

Pipelined per-channel energy calibration evaluator in the wavelength capture path. Takes each photon event (channel, phase pulse height, timestamp), reads that channel's 64-bit quadratic coefficient word from the energy-coefficient LUT BRAM (port A), and emits a calibrated, clamped energy with the photon's sideband. It sits directly upstream of the LUT on port A (address/read) and feeds the photon packetizer downstream. One photon per cycle, no backpressure.

## Interface
- `CHAN_W`, 10: channel/LUT address width (1024 entries)
- `PH_W`, 16: signed phase width (Q1.15)
- `TS_W`, 32: timestamp sideband width
- `EW`, 16: unsigned output energy width
- `LUT_LATENCY`, 3: LUT read latency in cycles, with both prim and core output regs enabled
- `clk` in 1: sole clock; every register is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `photon_valid` in 1: photon event strobe
- `photon_chan` in CHAN_W: channel index
- `photon_phase` in PH_W: signed pulse height
- `photon_ts` in TS_W: timestamp
- `bram_addr` out CHAN_W: LUT port A address
- `bram_en_a` out 1: LUT port A enable
- `bram_we` out 1: LUT port A write enable, tied 0
- `bram_wr_data` out 64: tied 0
- `bram_rd_data` in 64: coefficient word
- `energy_valid` out 1: result strobe
- `energy` out EW: calibrated energy
- `energy_chan` out CHAN_W, `energy_ts` out TS_W: delayed sideband
- `sat_count` out 32: only with `ENERGY_CAL_SAT_CNT_EN`

## Operation
- `bram_addr` = `photon_chan`, combinational, so the LUT samples the address on the photon's edge. `bram_en_a` = `!rst`.
- The coefficient word is split as c2 = [63:48] s16 Q1.15, c1 = [47:32] s16, c0 = [31:0] s32 (integer energy units).
- Sideband (valid, phase, chan, ts) is carried through a LUT_LATENCY-deep shift register so it aligns with `bram_rd_data`.
- Horner evaluation, 4 register stages after alignment:
  - S1: m1 = c2*p, s32.
  - S2: t1 = (m1 >>> 15) + c1, s18.
  - S3: m2 = t1*p, s34.
  - S4: e = (m2 >>> 15) + c0, s33, then clamped to [0, 2^EW-1].
- `>>>` is an arithmetic shift (floor, no rounding). Internal widths are sized so nothing before the clamp overflows.
- Saturation is flagged when e < 0 or e > 2^EW-1.
- Event order is preserved; there is no reordering or dropping.
- LUT contents can be rewritten from port B at any time. Each photon uses whatever word the RAM returns for its sampling edge; no coherence is enforced.
- Reset:
  - All valid bits clear.
  - `energy_valid`, `energy`, `energy_chan`, `energy_ts`, `sat_count` = 0.
  - Photons in flight are discarded, and `photon_valid` is ignored while `rst` is high.

## Timing
- Photon accepted at edge t; its energy is presented with `energy_valid` = 1 during cycle t+LUT_LATENCY+4 (7 cycles at default).
- Throughput is one event per cycle. Back-to-back valids give back-to-back outputs with no gaps.
- Outputs are registered and hold their last value when `energy_valid` = 0.
- Reset asserted at edge r: no `energy_valid` for any photon accepted at or before r. The first valid output possible is 7 cycles after the first accepted photon following reset release.

## Configuration
- `ENERGY_CAL_SAT_CNT_EN` defined:
  - Port `sat_count` exists.
  - It increments by 1 on each output event that clamped.
  - It saturates at 2^32-1 and resets to 0.
- Undefined: the port and counter are absent. Clamping behaviour is identical in both cases.

## Test plan
- Offset only: LUT[5] = {c2=0, c1=0, c0=1000}, photon chan 5, phase 12345 at cycle 0 -> `energy_valid` in cycle 7, energy 1000, chan 5, ts unchanged.
- Linear: LUT[7] = {0, 16384, 0}, phase 8192 -> 4096. Phase -8192 -> 0, and `sat_count` +1 when enabled.
- Quadratic: LUT[9] = {16384, 0, 100}, phase 16384 -> 4196.
- High clamp: LUT[3] = {0, 0, 70000} -> 65535, `sat_count` +1. Followed by c0 = 65535 -> 65535 with no increment.
- Stream: 1024 consecutive photons on channels 0..1023 with distinct c0 = chan -> 1024 contiguous valids in cycles 7..1030, in order, energy = chan.
- Reset mid-stream: 10 back-to-back photons, `rst` high for 1 cycle at cycle 4 -> no output for photons accepted at cycles 0-4. Photons accepted at cycles 5-9 appear at cycles 12-16, and all outputs are 0 during reset.
